inst_fetch_buffer: RTL and testbench

INST_FETCH_BUFFER -- requirements
Module: inst_fetch_buffer

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_fifo.sv | 48 ++++
 rtl/inst_fetch_buffer.sv | 122 ++++++++++++
 tb/tb_inst_fetch_buffer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch buffer.
// Holds the fetch FSM state encoding and the queue entry layout.
package fetch_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;
    localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // Redirect targets are word aligned: the two low bits are discarded.
    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of {pc, inst} entries for the fetch buffer.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  fetch_entry_t           push_entry,
    input  logic                   pop,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Clear takes priority over a coincident push or pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= push_entry;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch_buffer.sv
// Instruction fetch unit: one outstanding memory request feeding a small queue.
// Define FETCH_STATS_EN to add pop and stall counters (fetch_cnt_o, stall_cnt_o).
module inst_fetch_buffer
    import fetch_pkg::*;
#(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] START_ADDR = 32'h0000_0000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    output logic               mem_req_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    input  logic               mem_ack_i,
    input  logic [INST_W-1:0]  mem_data_i,
    output logic [INST_W-1:0]  inst_o,
    output logic [ADDR_W-1:0]  pc_o,
    output logic               valid_o,
    input  logic               ready_i,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i,
`ifdef FETCH_STATS_EN
    output logic [31:0]        fetch_cnt_o,
    output logic [31:0]        stall_cnt_o,
`endif
    output fetch_state_e       state_o
);

    // Decode handshake: a pop happens on a rising edge where valid_o && ready_i
    // and no redirect is present; valid_o never depends on ready_i.
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              push, pop, clear;
    logic [CNT_W-1:0]  count;
    fetch_entry_t      head;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pc_q    <= START_ADDR;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        push    = 1'b0;
        clear   = redirect_i;
        pop     = valid_o && ready_i && !redirect_i;
        if (redirect_i) pc_d = align_word(redirect_pc_i);
        case (state_q)
            IDLE: begin
                if (start_i && !redirect_i && (count < DEPTH_CNT)) begin
                    state_d = REQ;
                    addr_d  = pc_q;
                end
            end
            REQ: begin
                // The request cannot be withdrawn; a redirect only marks its data as stale.
                if (redirect_i) begin
                    state_d = mem_ack_i ? IDLE : DROP;
                end else if (mem_ack_i) begin
                    push    = 1'b1;
                    pc_d    = pc_q + PC_STEP;
                    state_d = IDLE;
                end
            end
            DROP: begin
                if (mem_ack_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk_i),
        .rst        (rst_i),
        .clear      (clear),
        .push       (push),
        .push_entry ('{pc: pc_q, inst: mem_data_i}),
        .pop        (pop),
        .head       (head),
        .count      (count)
    );

    assign mem_req_o  = (state_q != IDLE);
    assign mem_addr_o = addr_q;
    assign valid_o    = (count != '0);
    // Gate the head so the outputs read zero while the storage holds stale data.
    assign inst_o     = valid_o ? head.inst : '0;
    assign pc_o       = valid_o ? head.pc   : '0;
    assign state_o    = state_q;

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (pop)                 fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (valid_o && !ready_i) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed self-checking bench for inst_fetch_buffer (DEPTH=4, START_ADDR=0).
// Covers fetch cadence, back-pressure, redirects, mid-request reset and optional stats.
module tb_inst_fetch_buffer;
    import fetch_pkg::*;

    logic         clk;
    logic         rst;
    logic         start;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ack;
    logic [31:0]  mem_data;
    logic [31:0]  inst;
    logic [31:0]  pc;
    logic         valid;
    logic         ready;
    logic         redirect;
    logic [31:0]  redirect_pc;
    fetch_state_e state;
`ifdef FETCH_STATS_EN
    logic [31:0]  fetch_cnt;
    logic [31:0]  stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic auto_ack = 1'b0;

    inst_fetch_buffer #(.DEPTH(4), .START_ADDR(32'h0000_0000)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .mem_req_o     (mem_req),
        .mem_addr_o    (mem_addr),
        .mem_ack_i     (mem_ack),
        .mem_data_i    (mem_data),
        .inst_o        (inst),
        .pc_o          (pc),
        .valid_o       (valid),
        .ready_i       (ready),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
`ifdef FETCH_STATS_EN
        .fetch_cnt_o   (fetch_cnt),
        .stall_cnt_o   (stall_cnt),
`endif
        .state_o       (state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h0A50_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Memory model answers in the cycle after the request becomes visible.
    task automatic cycle();
        if (auto_ack) begin
            mem_ack  = mem_req;
            mem_data = mem_word(mem_addr);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst         = 1'b1;
        start       = 1'b0;
        mem_ack     = 1'b0;
        mem_data    = '0;
        ready       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        auto_ack    = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic expect_pops(input int n, input logic [31:0] first_pc);
        int got = 0;
        int budget = 0;
        logic [31:0] exp_pc = first_pc;
        while (got < n && budget < 100) begin
            if (valid && ready) begin
                check("pop_pc", pc, exp_pc);
                check("pop_inst", inst, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                got++;
            end
            cycle();
            budget++;
        end
        if (got < n) check("pop_timeout", 32'(got), 32'(n));
    endtask

    task automatic wait_req(input logic [31:0] addr);
        int budget = 0;
        while (!(mem_req && mem_addr == addr) && budget < 60) begin
            cycle();
            budget++;
        end
        if (budget >= 60) check("wait_req_timeout", mem_addr, addr);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; mem_ack = 1'b0; mem_data = '0; ready = 1'b0;
        redirect = 1'b0; redirect_pc = '0;
        #2;
        // Reset values
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_state", 32'(state), 32'(IDLE));
        apply_reset();
        repeat (3) cycle();
        check("start_low_no_req", 32'(mem_req), 32'd0);

        // Streaming fetch, 1-cycle ack, decode always ready
        start = 1'b1; ready = 1'b1; auto_ack = 1'b1;
        expect_pops(4, 32'h0);

        // Back-pressure fills the queue, one pop re-enables fetching at 0x10
        apply_reset();
        start = 1'b1; ready = 1'b0; auto_ack = 1'b1;
        repeat (12) cycle();
        check("full_no_req", 32'(mem_req), 32'd0);
        check("full_valid", 32'(valid), 32'd1);
        check("full_head_pc", pc, 32'h0);
        check("full_head_inst", inst, mem_word(32'h0));
        ready = 1'b1;
        cycle();
        ready = 1'b0;
        check("after_pop_no_req", 32'(mem_req), 32'd0);
        check("after_pop_head_pc", pc, 32'h4);
        cycle();
        check("refetch_req", 32'(mem_req), 32'd1);
        check("refetch_addr", mem_addr, 32'h10);
        ready = 1'b1;
        expect_pops(4, 32'h4);

        // Redirect while request to 0x8 pending; ack arrives three cycles later
        apply_reset();
        start = 1'b1; ready = 1'b1; auto_ack = 1'b1;
        wait_req(32'h8);
        auto_ack = 1'b0; mem_ack = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h103;
        cycle();
        redirect = 1'b0;
        check("drop_state", 32'(state), 32'(DROP));
        check("drop_req", 32'(mem_req), 32'd1);
        check("drop_addr", mem_addr, 32'h8);
        check("drop_valid", 32'(valid), 32'd0);
        cycle();
        cycle();
        check("drop_addr_stable", mem_addr, 32'h8);
        mem_ack = 1'b1; mem_data = 32'hDEAD_BEEF;
        cycle();
        mem_ack = 1'b0;
        check("drop_done_state", 32'(state), 32'(IDLE));
        check("drop_done_valid", 32'(valid), 32'd0);
        cycle();
        check("redir_req", 32'(mem_req), 32'd1);
        check("redir_addr", mem_addr, 32'h100);
        auto_ack = 1'b1;
        expect_pops(2, 32'h100);

        // Redirect coincident with ack and pop while two entries are queued
        apply_reset();
        start = 1'b1; ready = 1'b0; auto_ack = 1'b1;
        wait_req(32'h8);
        check("pre_redir_head", pc, 32'h0);
        auto_ack = 1'b0;
        mem_ack = 1'b1; mem_data = 32'h1234_5678;
        ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
        cycle();
        mem_ack = 1'b0; ready = 1'b0; redirect = 1'b0;
        check("coinc_valid", 32'(valid), 32'd0);
        check("coinc_req", 32'(mem_req), 32'd0);
        check("coinc_state", 32'(state), 32'(IDLE));
        cycle();
        check("coinc_next_addr", mem_addr, 32'h200);

        // Reset pulse mid-request; a stale ack must be ignored
        apply_reset();
        start = 1'b1;
        cycle();
        check("mid_req_req", 32'(mem_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_req", 32'(mem_req), 32'd0);
        check("async_rst_state", 32'(state), 32'(IDLE));
        #1 rst = 1'b0;
        start = 1'b0;
        mem_ack = 1'b1; mem_data = 32'h0000_0BAD;
        cycle();
        cycle();
        mem_ack = 1'b0;
        check("stale_ack_valid", 32'(valid), 32'd0);
        check("stale_ack_req", 32'(mem_req), 32'd0);
        start = 1'b1;
        cycle();
        check("post_rst_addr", mem_addr, 32'h0);
        mem_ack = 1'b1; mem_data = 32'hCAFE_0001;
        cycle();
        mem_ack = 1'b0;
        check("post_rst_pc", pc, 32'h0);
        check("post_rst_inst", inst, 32'hCAFE_0001);

`ifdef FETCH_STATS_EN
        // Three stall cycles then five pops
        apply_reset();
        check("stats_rst_fetch", fetch_cnt, 32'd0);
        check("stats_rst_stall", stall_cnt, 32'd0);
        begin
            int pops = 0;
            int budget = 0;
            start = 1'b1; ready = 1'b0; auto_ack = 1'b1;
            while (!valid && budget < 20) begin
                cycle();
                budget++;
            end
            repeat (3) cycle();
            ready = 1'b1;
            budget = 0;
            while (pops < 5 && budget < 100) begin
                if (valid && ready) pops++;
                cycle();
                budget++;
            end
            check("stats_pops_seen", 32'(pops), 32'd5);
        end
        check("stats_fetch_cnt", fetch_cnt, 32'd5);
        check("stats_stall_cnt", stall_cnt, 32'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
